// File: rtl/softmax_pkg.sv
// Shared types and sizes for the softmax output path (flattener and row gather).
package softmax_pkg;

  localparam int SM_N      = 32;
  localparam int SM_DATA_W = 16;
  localparam int SM_ADDR_W = 5;

  typedef logic [SM_DATA_W-1:0] sm_word_t;
  typedef sm_word_t sm_row_t [SM_N];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } gather_state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// Tracks in-flight BRAM reads: RD_LAT-deep shift register of {vld, idx} whose
// last stage lines up with the data returned by the BRAM.
module rd_lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int IDX_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);

  logic [RD_LAT-1:0] vld_q;
  logic [IDX_W-1:0]  idx_q [RD_LAT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) idx_q[k] <= '0;
    end else begin
      vld_q[0] <= i_vld;
      idx_q[0] <= i_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  assign o_vld = vld_q[RD_LAT-1];
  assign o_idx = idx_q[RD_LAT-1];

endmodule

// File: rtl/bram_row_gather.sv
// Fetches an N-word row from a synchronous BRAM port, one read per cycle, and
// presents it as a parallel row register behind a valid/ready handshake.
module bram_row_gather
  import softmax_pkg::*;
#(
  parameter int N      = SM_N,
  parameter int DATA_W = SM_DATA_W,
  parameter int ADDR_W = SM_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_busy,
  output logic              o_start_ign,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_row [N],
  output logic              o_row_valid,
  input  logic              i_row_ready,
  output gather_state_e     o_state
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("bram_row_gather: RD_LAT must be 1 or 2");
  end

  gather_state_e     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              ign_q, ign_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] row_q [N];
  logic              accept;
  logic              cap_vld;
  logic [IDX_W-1:0]  cap_idx;

  // Handshake: the row transfers on a cycle where o_row_valid & i_row_ready are
  // both high; o_row_valid never drops before that and o_row is frozen meanwhile.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    valid_d   = valid_q;
    accept    = 1'b0;
    case (state_q)
      IDLE:  accept = i_start;
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + ADDR_W'(idx_d);
        end
      end
      DRAIN: begin
        if (cap_vld && cap_idx == LAST_IDX) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (i_row_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          accept  = i_start;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new start reuses the same first-read setup whether it came from IDLE or HOLD.
    if (accept) begin
      state_d   = ISSUE;
      base_d    = i_base_addr;
      idx_d     = '0;
      rd_en_d   = 1'b1;
      rd_addr_d = i_base_addr;
    end
    ign_d = i_start && !accept;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      idx_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ign_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      ign_q     <= ign_d;
      valid_q   <= valid_d;
    end
  end

  rd_lat_pipe #(
    .RD_LAT(RD_LAT),
    .IDX_W (IDX_W)
  ) u_rd_lat_pipe (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_vld(rd_en_q),
    .i_idx(idx_q),
    .o_vld(cap_vld),
    .o_idx(cap_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N; k++) row_q[k] <= '0;
    end else if (cap_vld) begin
      row_q[cap_idx] <= i_rd_data;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_start_ign = ign_q;
  assign o_rd_en     = rd_en_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_row       = row_q;
  assign o_row_valid = valid_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_bram_row_gather.sv
// Bench for bram_row_gather: one DUT per legal read latency, each with its own BRAM model.
module tb_bram_row_gather;
  import softmax_pkg::*;

  localparam int N = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start [2];
  logic [4:0]    base [2];
  logic          ready [2];
  logic          busy [2];
  logic          ign [2];
  logic          rd_en [2];
  logic [4:0]    rd_addr [2];
  logic [15:0]   rd_data [2];
  logic          valid [2];
  gather_state_e st [2];
  logic [15:0]   row0 [N];
  logic [15:0]   row1 [N];
  logic [15:0]   mem [N];

  bram_row_gather #(.RD_LAT(1)) u_dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_base_addr(base[0]),
    .o_busy(busy[0]), .o_start_ign(ign[0]), .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]),
    .i_rd_data(rd_data[0]), .o_row(row0), .o_row_valid(valid[0]),
    .i_row_ready(ready[0]), .o_state(st[0])
  );

  bram_row_gather #(.RD_LAT(2)) u_dut_l2 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_base_addr(base[1]),
    .o_busy(busy[1]), .o_start_ign(ign[1]), .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]),
    .i_rd_data(rd_data[1]), .o_row(row1), .o_row_valid(valid[1]),
    .i_row_ready(ready[1]), .o_state(st[1])
  );

  // BRAM models: latency 1 and latency 2
  logic [15:0] bq0, bq1a, bq1b;
  always @(posedge clk) begin
    if (rd_en[0]) bq0 <= mem[rd_addr[0]];
    if (rd_en[1]) bq1a <= mem[rd_addr[1]];
    bq1b <= bq1a;
  end
  assign rd_data[0] = bq0;
  assign rd_data[1] = bq1b;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] row_at(input int sel, input int k);
    return (sel == 0) ? row0[k] : row1[k];
  endfunction

  function automatic logic [15:0] model_word(input logic [4:0] b, input int k);
    logic [4:0] a;
    a = b + 5'(k);
    return mem[a];
  endfunction

  function automatic int row_errs(input int sel, input logic [4:0] b);
    int e = 0;
    for (int k = 0; k < N; k++) if (row_at(sel, k) !== model_word(b, k)) e++;
    return e;
  endfunction

  function automatic int nonzero_words(input int sel);
    int e = 0;
    for (int k = 0; k < N; k++) if (row_at(sel, k) !== 16'h0) e++;
    return e;
  endfunction

  task automatic check_reset_state(input int sel, input string tag);
    check($sformatf("%s_d%0d_busy", tag, sel), 32'(busy[sel]), 32'd0);
    check($sformatf("%s_d%0d_ign", tag, sel), 32'(ign[sel]), 32'd0);
    check($sformatf("%s_d%0d_rd_en", tag, sel), 32'(rd_en[sel]), 32'd0);
    check($sformatf("%s_d%0d_rd_addr", tag, sel), 32'(rd_addr[sel]), 32'd0);
    check($sformatf("%s_d%0d_valid", tag, sel), 32'(valid[sel]), 32'd0);
    check($sformatf("%s_d%0d_state", tag, sel), 32'(st[sel]), 32'(IDLE));
    check($sformatf("%s_d%0d_row_zero", tag, sel), 32'(nonzero_words(sel)), 32'd0);
  endtask

  // Drive a start at the current negedge, then watch the whole fetch cycle by
  // cycle against the timing rules: reads in cycles 1..N at base+c-1, row valid
  // first in cycle N+lat+1. Optionally pulse a stray start mid-fetch.
  task automatic fetch(input int sel, input logic [4:0] b, input bit inject);
    int lat, vcyc, seq_err, p;
    logic [15:0] prev0;
    logic [4:0]  ea;
    lat     = sel + 1;
    vcyc    = N + lat + 1;
    seq_err = 0;
    p       = $urandom_range(3, 28);
    prev0   = row_at(sel, 0);
    start[sel] = 1'b1;
    base[sel]  = b;
    @(posedge clk);
    for (int c = 1; c <= vcyc; c++) begin
      @(negedge clk);
      ea = b + 5'(c - 1);
      if (rd_en[sel] !== (c <= N)) seq_err++;
      if (c <= N && rd_addr[sel] !== ea) seq_err++;
      if (busy[sel] !== 1'b1) seq_err++;
      if (c < vcyc && valid[sel] !== 1'b0) seq_err++;
      if (inject && c == p + 1) check($sformatf("d%0d_ign_midfetch", sel), 32'(ign[sel]), 32'd1);
      else if (ign[sel] !== 1'b0) seq_err++;
      if (c <= lat + 1) check($sformatf("d%0d_no_early_cap_c%0d", sel, c), 32'(row_at(sel, 0)), 32'(prev0));
      if (c == 1) begin
        start[sel] = 1'b0;
        base[sel]  = 5'($urandom);
      end
      if (inject && c == p) start[sel] = 1'b1;
      if (inject && c == p + 1) start[sel] = 1'b0;
    end
    check($sformatf("d%0d_b%0d_seq_errs", sel, b), 32'(seq_err), 32'd0);
    check($sformatf("d%0d_b%0d_valid_at_%0d", sel, b, vcyc), 32'(valid[sel]), 32'd1);
    check($sformatf("d%0d_b%0d_row_errs", sel, b), 32'(row_errs(sel, b)), 32'd0);
  endtask

  // Keep ready low for wait_n cycles, then complete the handshake.
  task automatic release_row(input int sel, input logic [4:0] b, input int wait_n);
    int err = 0;
    ready[sel] = 1'b0;
    for (int c = 0; c < wait_n; c++) begin
      @(negedge clk);
      if (valid[sel] !== 1'b1 || rd_en[sel] !== 1'b0 || row_errs(sel, b) != 0) err++;
    end
    check($sformatf("d%0d_hold_stable", sel), 32'(err), 32'd0);
    ready[sel] = 1'b1;
    @(negedge clk);
    check($sformatf("d%0d_valid_drop", sel), 32'(valid[sel]), 32'd0);
    check($sformatf("d%0d_idle_busy", sel), 32'(busy[sel]), 32'd0);
    ready[sel] = 1'b0;
  endtask

  initial begin
    int err;
    logic [4:0] b;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; base[s] = '0; ready[s] = 1'b0;
    end
    for (int k = 0; k < N; k++) mem[k] = 16'h1000 + 16'(k);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state(0, "rst");
    check_reset_state(1, "rst");
    rst = 1'b0;

    // Straight row, base 0, ready already high: valid exactly one cycle.
    ready[0] = 1'b1;
    fetch(0, 5'd0, 1'b0);
    check("d0_row0_word0", 32'(row0[0]), 32'h1000);
    check("d0_row0_word31", 32'(row0[31]), 32'h101f);
    @(negedge clk);
    check("d0_one_cycle_valid", 32'(valid[0]), 32'd0);
    check("d0_back_idle", 32'(busy[0]), 32'd0);

    // Address wrap from base 30.
    fetch(0, 5'd30, 1'b0);
    check("wrap_row0", 32'(row0[0]), 32'(mem[30]));
    check("wrap_row2", 32'(row0[2]), 32'(mem[0]));
    @(negedge clk);
    ready[0] = 1'b0;

    // Latency-2 build, first row after reset.
    ready[1] = 1'b1;
    fetch(1, 5'd0, 1'b0);
    @(negedge clk);
    check("d1_one_cycle_valid", 32'(valid[1]), 32'd0);
    ready[1] = 1'b0;

    // Long hold with a stray start, then chained start with ready at base 16.
    fetch(0, 5'd5, 1'b0);
    err = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 11) check("hold_ign_pulse", 32'(ign[0]), 32'd1);
      else if (ign[0] !== 1'b0) err++;
      if (rd_en[0] !== 1'b0 || valid[0] !== 1'b1 || st[0] !== HOLD || row_errs(0, 5'd5) != 0) err++;
      if (c == 10) begin start[0] = 1'b1; base[0] = 5'd3; end
      if (c == 11) start[0] = 1'b0;
    end
    check("hold_errs", 32'(err), 32'd0);
    ready[0] = 1'b1;
    fetch(0, 5'd16, 1'b0);
    check("chain_row0", 32'(row0[0]), 32'(mem[16]));
    check("chain_row16", 32'(row0[16]), 32'(mem[0]));
    @(negedge clk);
    ready[0] = 1'b0;

    // Reset in cycle 10 of a fetch.
    start[0] = 1'b1; base[0] = 5'd7;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_reset_state(0, "midrst");
    check_reset_state(1, "midrst");
    @(negedge clk);
    rst = 1'b0;
    err = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rd_en[0] !== 1'b0 || valid[0] !== 1'b0 || nonzero_words(0) != 0) err++;
    end
    check("post_rst_quiet", 32'(err), 32'd0);
    ready[0] = 1'b1;
    fetch(0, 5'd9, 1'b0);
    @(negedge clk);
    ready[0] = 1'b0;

    // Randomized rows on both latencies.
    for (int k = 0; k < N; k++) mem[k] = 16'($urandom);
    for (int i = 0; i < 10; i++) begin
      int sel;
      sel = $urandom_range(0, 1);
      b   = 5'($urandom);
      fetch(sel, b, 1'($urandom_range(0, 1)));
      release_row(sel, b, $urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
